apb_decoder: RTL and testbench

APB_DECODER -- requirements
Module: ApbDecoder

---
 rtl/apb_pkg.sv | 5 +
 rtl/apb_decoder.sv | 95 +++++++++
 tb/tb_apb_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and error response data for the APB decoder
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/apb_decoder.sv
// apb_decoder: one-master to N-slave APB bridge with index decode, unmapped-slave error and access timeout
module apb_decoder
  import apb_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int SEL_BITS = 2,
  localparam int NSLAVES = 2 ** SEL_BITS,
  parameter logic [NSLAVES-1:0] SLAVE_MASK = '1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [AWIDTH+SEL_BITS-1:0] m_PADDR,
  input  logic                       m_PSEL,
  input  logic                       m_PENABLE,
  input  logic                       m_PWRITE,
  input  logic [31:0]                m_PWDATA,
  output logic                       m_PREADY,
  output logic [31:0]                m_PRDATA,
  output logic                       m_PSLVERR,
  output logic [AWIDTH-1:0]          s_PADDR,
  output logic [NSLAVES-1:0]         s_PSEL,
  output logic                       s_PENABLE,
  output logic                       s_PWRITE,
  output logic [31:0]                s_PWDATA,
  input  logic [NSLAVES-1:0]         s_PREADY,
  input  logic [NSLAVES*32-1:0]      s_PRDATA
);
  localparam int TCW = $clog2(TIMEOUT + 1);
  apb_state_t state;
  logic [SEL_BITS-1:0] idx;
  logic [TCW-1:0] cnt;
  logic [SEL_BITS-1:0] m_idx;
  logic rdy;
  logic expired;
  logic [31:0] rdata;
  assign m_idx = m_PADDR[AWIDTH +: SEL_BITS];
  assign rdy = s_PREADY[idx];
  assign expired = cnt == TCW'(TIMEOUT - 1);
  assign rdata = s_PRDATA[{idx, 5'd0} +: 32];
  // ready is checked before expiry so a late ready still completes normally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      m_PREADY <= 1'b0;
      m_PRDATA <= '0;
      m_PSLVERR <= 1'b0;
      s_PADDR <= '0;
      s_PSEL <= '0;
      s_PENABLE <= 1'b0;
      s_PWRITE <= 1'b0;
      s_PWDATA <= '0;
    end else begin
      case (state)
        IDLE: if (m_PSEL && m_PENABLE) begin
          s_PADDR <= m_PADDR[AWIDTH-1:0];
          s_PWRITE <= m_PWRITE;
          s_PWDATA <= m_PWDATA;
          idx <= m_idx;
          if (SLAVE_MASK[m_idx]) begin
            state <= SETUP;
            s_PSEL <= NSLAVES'(1) << m_idx;
          end else begin
            state <= RESP;
            m_PREADY <= 1'b1;
            m_PRDATA <= ERR_DATA;
            m_PSLVERR <= 1'b1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          s_PENABLE <= 1'b1;
          cnt <= '0;
        end
        ACCESS: if (rdy || expired) begin
          state <= RESP;
          s_PSEL <= '0;
          s_PENABLE <= 1'b0;
          m_PREADY <= 1'b1;
          m_PRDATA <= rdy ? (s_PWRITE ? 32'd0 : rdata) : ERR_DATA;
          m_PSLVERR <= !rdy;
        end else begin
          cnt <= cnt + TCW'(1);
        end
        RESP: begin
          state <= IDLE;
          m_PREADY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_decoder.sv
// tb_apb_decoder: directed checks of decode, wait states, timeout, unmapped error and reset abort
module tb_apb_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [13:0] m_paddr = '0, b_paddr = '0;
  logic m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0, b_psel = 1'b0, b_penable = 1'b0;
  logic [31:0] m_pwdata = '0;
  logic [3:0] s_pready = '0;
  logic [127:0] s_prdata = {32'hA5A5_0003, 32'h1234_5678, 32'h0000_2222, 32'h0000_1000};
  logic a_pready, a_pslverr, a_spen, a_spwrite, b_pready, b_pslverr, b_spen, b_spwrite;
  logic [31:0] a_prdata, a_spwdata, b_prdata, b_spwdata;
  logic [11:0] a_spaddr, b_spaddr;
  logic [3:0] a_spsel, b_spsel;
  int checks = 0, errors = 0;
  int hold;

  always #5 clk = ~clk;

  apb_decoder #(.TIMEOUT(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .m_PADDR(m_paddr), .m_PSEL(m_psel), .m_PENABLE(m_penable),
    .m_PWRITE(m_pwrite), .m_PWDATA(m_pwdata), .m_PREADY(a_pready), .m_PRDATA(a_prdata),
    .m_PSLVERR(a_pslverr), .s_PADDR(a_spaddr), .s_PSEL(a_spsel), .s_PENABLE(a_spen),
    .s_PWRITE(a_spwrite), .s_PWDATA(a_spwdata), .s_PREADY(s_pready), .s_PRDATA(s_prdata)
  );

  apb_decoder #(.SLAVE_MASK(4'b1011)) dut_b (
    .clk(clk), .reset_n(reset_n), .m_PADDR(b_paddr), .m_PSEL(b_psel), .m_PENABLE(b_penable),
    .m_PWRITE(m_pwrite), .m_PWDATA(m_pwdata), .m_PREADY(b_pready), .m_PRDATA(b_prdata),
    .m_PSLVERR(b_pslverr), .s_PADDR(b_spaddr), .s_PSEL(b_spsel), .s_PENABLE(b_spen),
    .s_PWRITE(b_spwrite), .s_PWDATA(b_spwdata), .s_PREADY(s_pready), .s_PRDATA(s_prdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // zero-wait read on dut_a; master keeps its access phase through the response cycle
  task automatic xfer(input logic [13:0] addr, input logic [31:0] exp);
    int lat;
    m_paddr = addr; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    tick;
    m_penable = 1'b1;
    tick;
    lat = 1;
    while (!a_pready && lat < 20) begin
      check("onehot_psel", 32'($onehot0(a_spsel)), 1);
      tick;
      lat++;
    end
    check("xfer_latency", lat, 3);
    check("xfer_rdata", a_prdata, exp);
    check("xfer_slverr", a_pslverr, 0);
    check("xfer_psel_resp", a_spsel, 0);
    tick;
    check("xfer_pready_drop", a_pready, 0);
    check("xfer_no_recapture", a_spsel, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    tick;
    tick;
    check("rst_psel", a_spsel, 0);
    check("rst_penable", a_spen, 0);
    check("rst_pready", a_pready, 0);
    check("rst_pslverr", a_pslverr, 0);
    check("rst_prdata", a_prdata, 0);
    check("rst_b_pready", b_pready, 0);
    reset_n = 1'b1;
    m_paddr = {2'd2, 12'h0A4}; m_psel = 1'b1; s_pready = 4'b1111;
    tick;
    check("t1_setup_no_capture", a_spsel, 0);
    m_penable = 1'b1;
    tick;
    check("t1_setup_psel", a_spsel, 4'b0100);
    check("t1_setup_penable", a_spen, 0);
    check("t1_spaddr", a_spaddr, 12'h0A4);
    tick;
    check("t1_access_psel", a_spsel, 4'b0100);
    check("t1_access_penable", a_spen, 1);
    check("t1_access_pready", a_pready, 0);
    tick;
    check("t1_pready", a_pready, 1);
    check("t1_prdata", a_prdata, 32'h1234_5678);
    check("t1_pslverr", a_pslverr, 0);
    check("t1_psel_off", a_spsel, 0);
    check("t1_penable_off", a_spen, 0);
    m_psel = 1'b0; m_penable = 1'b0;
    tick;
    check("t1_pready_drop", a_pready, 0);
    m_paddr = {2'd1, 12'h010}; m_pwrite = 1'b1; m_pwdata = 32'hCAFE_BABE; m_psel = 1'b1;
    s_pready = 4'b1101;
    tick;
    m_penable = 1'b1;
    tick;
    check("t2_psel", a_spsel, 4'b0010);
    check("t2_pwrite", a_spwrite, 1);
    check("t2_pwdata", a_spwdata, 32'hCAFE_BABE);
    hold = a_spsel[1];
    m_paddr = {2'd0, 12'hFFF}; m_pwrite = 1'b0; m_pwdata = '0;
    tick;
    repeat (5) begin
      hold += a_spsel[1];
      check("t2_wait", {a_pready, a_spen}, 2'b01);
      tick;
    end
    s_pready[1] = 1'b1;
    hold += a_spsel[1];
    tick;
    check("t2_psel_cycles", hold, 7);
    check("t2_pready", a_pready, 1);
    check("t2_prdata", a_prdata, 0);
    check("t2_pslverr", a_pslverr, 0);
    check("t2_psel_off", a_spsel, 0);
    check("t2_spaddr_held", a_spaddr, 12'h010);
    check("t2_pwdata_held", a_spwdata, 32'hCAFE_BABE);
    m_psel = 1'b0; m_penable = 1'b0; s_pready = '0;
    tick;
    check("t2_pready_drop", a_pready, 0);
    m_paddr = {2'd2, 12'h100}; m_psel = 1'b1; s_pready = 4'b1011;
    tick;
    m_penable = 1'b1;
    tick;
    tick;
    repeat (7) begin
      check("t3_wait", {a_pready, a_spen, a_spsel}, 6'b010100);
      tick;
    end
    check("t3_last_access", {a_pready, a_spen, a_spsel}, 6'b010100);
    tick;
    check("t3_pready", a_pready, 1);
    check("t3_prdata", a_prdata, 32'hFFFF_FFFF);
    check("t3_pslverr", a_pslverr, 1);
    check("t3_psel_off", a_spsel, 0);
    check("t3_penable_off", a_spen, 0);
    m_psel = 1'b0; m_penable = 1'b0;
    tick;
    check("t3_pready_drop", a_pready, 0);
    m_paddr = {2'd3, 12'h000}; m_psel = 1'b1; s_pready = 4'b0111;
    tick;
    m_penable = 1'b1;
    tick;
    tick;
    repeat (7) tick;
    check("t4_still_access", {a_pready, a_spen}, 2'b01);
    s_pready = 4'b1111;
    tick;
    check("t4_pready", a_pready, 1);
    check("t4_ready_wins_data", a_prdata, 32'hA5A5_0003);
    check("t4_ready_wins_err", a_pslverr, 0);
    m_psel = 1'b0; m_penable = 1'b0;
    tick;
    xfer({2'd0, 12'h004}, 32'h0000_1000);
    xfer({2'd3, 12'h008}, 32'hA5A5_0003);
    m_psel = 1'b0; m_penable = 1'b0;
    tick;
    m_paddr = {2'd0, 12'h000}; m_psel = 1'b1; s_pready = '0;
    tick;
    m_penable = 1'b1;
    tick;
    tick;
    check("t6_in_access", a_spen, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_psel", a_spsel, 0);
    check("t6_async_penable", a_spen, 0);
    m_psel = 1'b0; m_penable = 1'b0;
    repeat (3) begin
      tick;
      check("t6_no_pready", a_pready, 0);
    end
    reset_n = 1'b1;
    s_pready = 4'b1111;
    xfer({2'd0, 12'h000}, 32'h0000_1000);
    m_psel = 1'b0; m_penable = 1'b0;
    b_paddr = {2'd2, 12'h020}; b_psel = 1'b1;
    tick;
    b_penable = 1'b1;
    tick;
    check("t7_pready", b_pready, 1);
    check("t7_prdata", b_prdata, 32'hFFFF_FFFF);
    check("t7_pslverr", b_pslverr, 1);
    check("t7_no_psel", {b_spen, b_spsel}, 0);
    tick;
    check("t7_pready_drop", b_pready, 0);
    check("t7_still_no_psel", b_spsel, 0);
    b_paddr = {2'd3, 12'h000}; b_penable = 1'b0;
    tick;
    b_penable = 1'b1;
    tick;
    check("t7_mapped_psel", b_spsel, 4'b1000);
    tick;
    tick;
    check("t7_mapped_pready", b_pready, 1);
    check("t7_mapped_prdata", b_prdata, 32'hA5A5_0003);
    check("t7_mapped_pslverr", b_pslverr, 0);
    b_psel = 1'b0; b_penable = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
